reset_sequencer: RTL and testbench

//   Parametrised reset sequencer: successor to the single-output reset block in the video top level.

---
 rtl/reset_sequencer_if.sv | 31 +++
 rtl/reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the blocks it controls.
// master = sequencer side, slave = lock source / reset consumers.
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int LOSS_W     = 8
);
    logic                  pll_lock;
    logic                  sw_reset;
    logic [NUM_STAGES-1:0] reset_out;
    logic                  all_ready;
    logic [1:0]            state;
    logic [LOSS_W-1:0]     lock_loss_count;

    modport master (
        input  pll_lock,
        input  sw_reset,
        output reset_out,
        output all_ready,
        output state,
        output lock_loss_count
    );

    modport slave (
        output pll_lock,
        output sw_reset,
        input  reset_out,
        input  all_ready,
        input  state,
        input  lock_loss_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: debounces pll_lock, holds, then releases reset_out[0..N-1]
// in index order; any lock loss or soft reset restarts the whole sequence.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   WAIT_LOCK  | all stages in reset, waiting for the filtered lock
//   HOLD       | lock accepted, hold timer running, all stages in reset
//   RELEASE    | stages being released one per STAGE_GAP cycles
//   RUN        | every stage released, all_ready = 1
module reset_sequencer #(
    parameter int NUM_STAGES    = 3,
    parameter int FILTER_CYCLES = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 8,
    parameter int LOSS_W        = 8
) (
    input logic               clk,
    input logic               NRST,
    reset_sequencer_if.master bus
);
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RELEASE   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [FW-1:0]         FILT_FULL = FW'(FILTER_CYCLES);
    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [GW-1:0]         GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [IW-1:0]         IDX_FIRST = IW'(1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);
    localparam logic [LOSS_W-1:0]     LOSS_MAX  = {LOSS_W{1'b1}};

    logic                  lock_m;
    logic                  lock_s;
    logic [FW-1:0]         fcnt_q;
    logic                  lock_ok;
    logic [1:0]            state_q;
    logic [HW-1:0]         hcnt_q;
    logic [GW-1:0]         gcnt_q;
    logic [IW-1:0]         idx_q;
    logic [NUM_STAGES-1:0] reset_out_q;
    logic                  all_ready_q;
    logic [LOSS_W-1:0]     loss_q;
    logic                  lost;

    // Soft reset also flushes the synchroniser so a restart sees the same
    // lock latency as a cold start.
    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else if (bus.sw_reset) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            fcnt_q <= '0;
        end else if (bus.sw_reset || !lock_s) begin
            fcnt_q <= '0;
        end else if (fcnt_q != FILT_FULL) begin
            fcnt_q <= fcnt_q + FW'(1);
        end
    end

    assign lock_ok = (fcnt_q == FILT_FULL);
    assign lost    = !lock_s && ((state_q == ST_RELEASE) || (state_q == ST_RUN));

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            loss_q <= '0;
        end else if (lost && (loss_q != LOSS_MAX)) begin
            loss_q <= loss_q + LOSS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            state_q     <= ST_WAIT_LOCK;
            reset_out_q <= '1;
            all_ready_q <= 1'b0;
            hcnt_q      <= '0;
            gcnt_q      <= '0;
            idx_q       <= '0;
        end else if (bus.sw_reset || lost) begin
            state_q     <= ST_WAIT_LOCK;
            reset_out_q <= '1;
            all_ready_q <= 1'b0;
            hcnt_q      <= '0;
            gcnt_q      <= '0;
            idx_q       <= '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (lock_ok) begin
                        state_q <= ST_HOLD;
                        hcnt_q  <= HOLD_LAST;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_q <= ST_WAIT_LOCK;
                    end else if (hcnt_q == '0) begin
                        reset_out_q[0] <= 1'b0;
                        gcnt_q         <= GAP_LAST;
                        idx_q          <= IDX_FIRST;
                        if (NUM_STAGES == 1) begin
                            state_q     <= ST_RUN;
                            all_ready_q <= 1'b1;
                        end else begin
                            state_q <= ST_RELEASE;
                        end
                    end else begin
                        hcnt_q <= hcnt_q - HW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (gcnt_q == '0) begin
                        reset_out_q <= reset_out_q & ~(STAGE_ONE << idx_q);
                        gcnt_q      <= GAP_LAST;
                        if (idx_q == IDX_LAST) begin
                            state_q     <= ST_RUN;
                            all_ready_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        gcnt_q <= gcnt_q - GW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.reset_out       = reset_out_q;
    assign bus.all_ready       = all_ready_q;
    assign bus.state           = state_q;
    assign bus.lock_loss_count = loss_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues expected output changes
// (with the edge they must occur on); a monitor compares every observed change.
module tb_reset_sequencer;
    logic clk  = 1'b0;
    logic NRST = 1'b1;

    reset_sequencer_if #(.NUM_STAGES(3), .LOSS_W(8)) bus ();

    reset_sequencer #(
        .NUM_STAGES(3), .FILTER_CYCLES(4), .HOLD_CYCLES(16), .STAGE_GAP(8), .LOSS_W(8)
    ) dut (
        .clk (clk),
        .NRST(NRST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        int         at;
        logic [2:0] ro;
        logic [1:0] st;
        logic       ar;
        logic [7:0] cnt;
    } ev_t;

    typedef struct {
        string      nm;
        logic [2:0] ro;
        logic [1:0] st;
        logic       ar;
        logic [7:0] cnt;
        bit         cnt_only;
    } dc_t;

    ev_t  evq[$];
    dc_t  dq[$];
    event dchk;
    bit   chk_en = 1'b1;
    bit   fin    = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_ev(input int at, input logic [2:0] ro, input logic [1:0] st,
                             input logic ar, input logic [7:0] cnt);
        ev_t e;
        e.at = at; e.ro = ro; e.st = st; e.ar = ar; e.cnt = cnt;
        evq.push_back(e);
    endtask

    task automatic dcheck(input string nm, input logic [2:0] ro, input logic [1:0] st,
                          input logic ar, input logic [7:0] cnt, input bit cnt_only);
        dc_t d;
        d.nm = nm; d.ro = ro; d.st = st; d.ar = ar; d.cnt = cnt; d.cnt_only = cnt_only;
        dq.push_back(d);
        -> dchk;
        #0;
    endtask

    // Monitor: sole owner of the comparison counters.
    initial begin
        logic [13:0] cur;
        logic [13:0] prev;
        bit          have_prev;
        ev_t         e;
        dc_t         d;
        have_prev = 1'b0;
        prev      = '0;
        forever begin
            @(negedge clk or dchk);
            if (clk == 1'b1) begin
                while (dq.size() > 0) begin
                    d = dq.pop_front();
                    n_cmp++;
                    if (d.cnt_only) begin
                        if (bus.lock_loss_count !== d.cnt) begin
                            n_bad++;
                            $display("FAIL %s: got cnt=%0d, required cnt=%0d", d.nm,
                                     bus.lock_loss_count, d.cnt);
                        end
                    end else if ({bus.reset_out, bus.state, bus.all_ready, bus.lock_loss_count}
                                 !== {d.ro, d.st, d.ar, d.cnt}) begin
                        n_bad++;
                        $display("FAIL %s: got ro=%b st=%0d ar=%b cnt=%0d, required ro=%b st=%0d ar=%b cnt=%0d",
                                 d.nm, bus.reset_out, bus.state, bus.all_ready, bus.lock_loss_count,
                                 d.ro, d.st, d.ar, d.cnt);
                    end
                end
                if (fin) begin
                    n_cmp++;
                    if (evq.size() != 0) begin
                        n_bad++;
                        $display("FAIL leftover_events: got %0d pending, required 0 (next at edge %0d)",
                                 evq.size(), evq[0].at);
                    end
                    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
                    $finish;
                end
            end else begin
                cur = {bus.reset_out, bus.state, bus.all_ready, bus.lock_loss_count};
                if (have_prev && chk_en && (cur !== prev)) begin
                    n_cmp++;
                    if (!(bus.reset_out inside {3'b111, 3'b110, 3'b100, 3'b000})) begin
                        n_bad++;
                        $display("FAIL stage_order: got ro=%b at edge %0d, required ordered release",
                                 bus.reset_out, ecnt);
                    end
                    n_cmp++;
                    if (evq.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_change: got ro=%b st=%0d ar=%b cnt=%0d at edge %0d, required no change",
                                 bus.reset_out, bus.state, bus.all_ready, bus.lock_loss_count, ecnt);
                    end else begin
                        e = evq.pop_front();
                        if (cur !== {e.ro, e.st, e.ar, e.cnt}) begin
                            n_bad++;
                            $display("FAIL event_value: got ro=%b st=%0d ar=%b cnt=%0d, required ro=%b st=%0d ar=%b cnt=%0d",
                                     bus.reset_out, bus.state, bus.all_ready, bus.lock_loss_count,
                                     e.ro, e.st, e.ar, e.cnt);
                        end
                        n_cmp++;
                        if (ecnt != e.at) begin
                            n_bad++;
                            $display("FAIL event_edge: got edge %0d, required edge %0d", ecnt, e.at);
                        end
                    end
                end
                prev      = cur;
                have_prev = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b;
        bus.pll_lock = 1'b1;
        bus.sw_reset = 1'b0;
        #1 NRST = 1'b0;
        step(3);
        dcheck("reset_state", 3'b111, 2'd0, 1'b0, 8'd0, 1'b0);

        // Cold start, lock stable from E1 = b+1
        NRST = 1'b1;
        b = ecnt;
        expect_ev(b + 7,  3'b111, 2'd1, 1'b0, 8'd0);
        expect_ev(b + 23, 3'b110, 2'd2, 1'b0, 8'd0);
        expect_ev(b + 31, 3'b100, 2'd2, 1'b0, 8'd0);
        expect_ev(b + 39, 3'b000, 2'd3, 1'b1, 8'd0);
        step(45);

        // One-cycle lock glitch sampled at E3 restarts the filter
        NRST = 1'b0;
        expect_ev(ecnt, 3'b111, 2'd0, 1'b0, 8'd0);
        step(2);
        NRST = 1'b1;
        b = ecnt;
        expect_ev(b + 10, 3'b111, 2'd1, 1'b0, 8'd0);
        expect_ev(b + 26, 3'b110, 2'd2, 1'b0, 8'd0);
        expect_ev(b + 34, 3'b100, 2'd2, 1'b0, 8'd0);
        expect_ev(b + 42, 3'b000, 2'd3, 1'b1, 8'd0);
        step(2);
        bus.pll_lock = 1'b0;
        step(1);
        bus.pll_lock = 1'b1;
        step(45);

        // Two-cycle lock drop in RUN
        b = ecnt;
        bus.pll_lock = 1'b0;
        expect_ev(b + 3,  3'b111, 2'd0, 1'b0, 8'd1);
        expect_ev(b + 9,  3'b111, 2'd1, 1'b0, 8'd1);
        expect_ev(b + 25, 3'b110, 2'd2, 1'b0, 8'd1);
        expect_ev(b + 33, 3'b100, 2'd2, 1'b0, 8'd1);
        expect_ev(b + 41, 3'b000, 2'd3, 1'b1, 8'd1);
        step(2);
        bus.pll_lock = 1'b1;
        step(45);

        // sw_reset held 3 cycles in RUN, then a 1-cycle pulse in RELEASE (110)
        b = ecnt;
        bus.sw_reset = 1'b1;
        expect_ev(b + 1,  3'b111, 2'd0, 1'b0, 8'd1);
        expect_ev(b + 10, 3'b111, 2'd1, 1'b0, 8'd1);
        expect_ev(b + 26, 3'b110, 2'd2, 1'b0, 8'd1);
        step(3);
        bus.sw_reset = 1'b0;
        step(25);
        bus.sw_reset = 1'b1;
        b = ecnt + 1;
        expect_ev(b,      3'b111, 2'd0, 1'b0, 8'd1);
        expect_ev(b + 7,  3'b111, 2'd1, 1'b0, 8'd1);
        expect_ev(b + 23, 3'b110, 2'd2, 1'b0, 8'd1);
        expect_ev(b + 31, 3'b100, 2'd2, 1'b0, 8'd1);
        step(1);
        bus.sw_reset = 1'b0;
        step(33);

        // NRST while reset_out = 100, checked before the next clock edge
        NRST = 1'b0;
        #1;
        expect_ev(ecnt, 3'b111, 2'd0, 1'b0, 8'd0);
        dcheck("nrst_async", 3'b111, 2'd0, 1'b0, 8'd0, 1'b0);
        step(2);
        chk_en = 1'b0;

        // 300 lock losses, each forced just after bit 0 releases
        NRST = 1'b1;
        for (int i = 0; i < 254; i++) begin
            step(24);
            bus.pll_lock = 1'b0;
            step(2);
            bus.pll_lock = 1'b1;
        end
        step(2);
        dcheck("loss_count_254", 3'b000, 2'd0, 1'b0, 8'd254, 1'b1);
        step(24);
        bus.pll_lock = 1'b0;
        step(2);
        bus.pll_lock = 1'b1;
        step(2);
        dcheck("loss_count_255", 3'b000, 2'd0, 1'b0, 8'd255, 1'b1);
        for (int i = 0; i < 45; i++) begin
            step(24);
            bus.pll_lock = 1'b0;
            step(2);
            bus.pll_lock = 1'b1;
        end
        step(2);
        dcheck("loss_count_sat", 3'b000, 2'd0, 1'b0, 8'd255, 1'b1);

        fin = 1'b1;
        -> dchk;
    end
endmodule
